// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP+ACCESS transfer
// and returns one response per command, with a wait-state timeout.
module apb_master #(
    parameter int unsigned BUS_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
    input  logic [BUS_WIDTH/8-1:0]  cmd_strb_i,
    output logic                    rsp_valid_o,
    output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [BUS_WIDTH-1:0]    pwdata_o,
    output logic [BUS_WIDTH/8-1:0]  pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [BUS_WIDTH-1:0]    prdata_i
);

    localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_FIRE  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   wait_cnt_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [BUS_WIDTH-1:0]   rsp_rdata_q;
    logic                   rsp_err_q;
    logic                   rsp_timeout_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [BUS_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]  pstrb_q;
    logic                   timeout_hit;

    // This ACCESS cycle would be the TIMEOUT_CYCLES-th one without pready.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready_i && (wait_cnt_q == CNT_FIRE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        pwrite_q    <= cmd_write_i;
                        paddr_q     <= cmd_addr_i;
                        pwdata_q    <= cmd_write_i ? cmd_wdata_i : '0;
                        pstrb_q     <= cmd_write_i ? cmd_strb_i : '0;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!pready_i && (wait_cnt_q != CNT_MAX)) begin
                        wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
                    end
                    // Completion takes priority over a coincident timeout.
                    if (pready_i) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata_i;
                        state_q       <= ST_IDLE;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with hand-computed expectations, TIMEOUT_CYCLES = 4.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_strb;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [63:0] prdata;

    int n_checks = 0;
    int n_pass   = 0;

    apb_master #(.BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one command in the current (IDLE) cycle and follow it to its response cycle.
    task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] st, input int nwait,
                        input bit slverr, input logic [63:0] rd, input bit exp_err,
                        input bit exp_to, input logic [63:0] exp_rd, input int exp_access);
        int access_cnt;
        logic [63:0] exp_wd;
        logic [7:0]  exp_st;
        exp_wd = wr ? wd : 64'h0;
        exp_st = wr ? st : 8'h0;
        check({tag, ".ready_idle"}, 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        tick();
        cmd_valid = 1'b0; cmd_wdata = '1; cmd_strb = '1; cmd_addr = '1;
        check({tag, ".setup_psel"},    64'(psel),      64'h1);
        check({tag, ".setup_penable"}, 64'(penable),   64'h0);
        check({tag, ".setup_ready"},   64'(cmd_ready), 64'h0);
        check({tag, ".setup_pwrite"},  64'(pwrite),    64'(wr));
        check({tag, ".setup_paddr"},   64'(paddr),     64'(addr));
        check({tag, ".setup_pwdata"},  pwdata,         exp_wd);
        check({tag, ".setup_pstrb"},   64'(pstrb),     64'(exp_st));
        pslverr = slverr; prdata = rd;
        tick();
        access_cnt = 0;
        while (psel && access_cnt < 20) begin
            check({tag, ".acc_penable"}, 64'(penable), 64'h1);
            check({tag, ".acc_paddr"},   64'(paddr),   64'(addr));
            check({tag, ".acc_pwdata"},  pwdata,       exp_wd);
            check({tag, ".acc_pstrb"},   64'(pstrb),   64'(exp_st));
            check({tag, ".acc_rspv"},    64'(rsp_valid), 64'h0);
            pready = (access_cnt == nwait);
            access_cnt++;
            tick();
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 64'hBAD0_BAD0_BAD0_BAD0;
        check({tag, ".access_cycles"}, 64'(access_cnt),  64'(exp_access));
        check({tag, ".rsp_valid"},     64'(rsp_valid),   64'h1);
        check({tag, ".rsp_err"},       64'(rsp_err),     64'(exp_err));
        check({tag, ".rsp_timeout"},   64'(rsp_timeout), 64'(exp_to));
        check({tag, ".rsp_rdata"},     rsp_rdata,        exp_rd);
        check({tag, ".rsp_psel"},      64'(psel),        64'h0);
        check({tag, ".rsp_penable"},   64'(penable),     64'h0);
        check({tag, ".rsp_ready"},     64'(cmd_ready),   64'h1);
    endtask

    // One idle cycle after a response: pulse ends, fields hold.
    task automatic after_rsp(input string tag, input bit exp_err, input logic [63:0] exp_rd);
        tick();
        check({tag, ".rsp_pulse_end"}, 64'(rsp_valid), 64'h0);
        check({tag, ".rsp_err_hold"},  64'(rsp_err),   64'(exp_err));
        check({tag, ".rsp_rd_hold"},   rsp_rdata,      exp_rd);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst.cmd_ready", 64'(cmd_ready),   64'h1);
        check("rst.rsp_valid", 64'(rsp_valid),   64'h0);
        check("rst.psel",      64'(psel),        64'h0);
        check("rst.penable",   64'(penable),     64'h0);
        check("rst.paddr",     64'(paddr),       64'h0);
        check("rst.pwdata",    pwdata,           64'h0);
        check("rst.rsp_err",   64'(rsp_err),     64'h0);
        tick();

        xfer("wr0", 1'b1, 32'h10, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1'b0, 64'h5555,
             1'b0, 1'b0, 64'h0, 1);
        after_rsp("wr0", 1'b0, 64'h0);
        xfer("rd3", 1'b0, 32'h20, 64'hFFFF_0000_FFFF_0000, 8'hF0, 3, 1'b0, 64'h1234,
             1'b0, 1'b0, 64'h1234, 4);
        after_rsp("rd3", 1'b0, 64'h1234);
        xfer("slverr", 1'b1, 32'h30, 64'h0000_0000_CAFE_F00D, 8'h0F, 1, 1'b1, 64'h7777,
             1'b1, 1'b0, 64'h0, 2);
        after_rsp("slverr", 1'b1, 64'h0);
        xfer("tmo", 1'b0, 32'h40, 64'h0, 8'h00, 99, 1'b0, 64'hABCD,
             1'b1, 1'b1, 64'h0, 4);
        after_rsp("tmo", 1'b1, 64'h0);
        xfer("edge4", 1'b0, 32'h44, 64'h0, 8'h00, 3, 1'b0, 64'h0000_0000_0000_BEEF,
             1'b0, 1'b0, 64'hBEEF, 4);
        after_rsp("edge4", 1'b0, 64'hBEEF);

        // Back-to-back: the second command is offered during the first response cycle.
        xfer("b2b_a", 1'b1, 32'h50, 64'h1111_2222_3333_4444, 8'hC3, 0, 1'b0, 64'h0,
             1'b0, 1'b0, 64'h0, 1);
        xfer("b2b_b", 1'b0, 32'h58, 64'h0, 8'h00, 1, 1'b0, 64'h8765_4321_0FED_CBA9,
             1'b0, 1'b0, 64'h8765_4321_0FED_CBA9, 2);
        after_rsp("b2b_b", 1'b0, 64'h8765_4321_0FED_CBA9);

        // Reset during ACCESS: aborted command yields no response.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 64'h99; cmd_strb = 8'h01;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid.in_access", 64'(penable), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.psel",      64'(psel),      64'h0);
        check("mid.penable",   64'(penable),   64'h0);
        check("mid.cmd_ready", 64'(cmd_ready), 64'h1);
        check("mid.rsp_valid", 64'(rsp_valid), 64'h0);
        check("mid.pwdata",    pwdata,         64'h0);
        check("mid.paddr",     64'(paddr),     64'h0);
        check("mid.rsp_rdata", rsp_rdata,      64'h0);
        tick();
        check("mid.no_rsp",    64'(rsp_valid), 64'h0);
        xfer("post", 1'b0, 32'h70, 64'h0, 8'h00, 0, 1'b0, 64'h0000_00AB_0000_00CD,
             1'b0, 1'b0, 64'h0000_00AB_0000_00CD, 1);
        after_rsp("post", 1'b0, 64'h0000_00AB_0000_00CD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
